// File: rtl/ws2812b_pkg.sv
// Shared types and timing constants for the WS2812B frame path.
package ws2812b_pkg;

    localparam int CLK_HZ       = 27_000_000;
    localparam int LATCH_US     = 300;
    localparam int BITS_PER_LED = 24;

    typedef enum logic [2:0] {
        ST_LATCH     = 3'd0,
        ST_IDLE      = 3'd1,
        ST_FETCH     = 3'd2,
        ST_SEND      = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb_t;

endpackage

// File: rtl/ws2812b_cycle_timer.sv
// Up-counter over 0..CYCLES-1 with synchronous clear-to-zero and a terminal-count pulse.
module ws2812b_cycle_timer #(
    parameter int CYCLES = 8100
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tc
);

    localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CYCLES - 1);

    logic [CNT_W-1:0] count_q, count_d;

    assign o_tc = i_en && (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = '0;
        end else if (i_en) begin
            count_d = o_tc ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ws2812b_frame_scheduler.sv
// Fetches N_LEDS pixels, hands each to the WS2812B bit driver, then holds the latch time.
// Build option: WS2812B_AUTO_REFRESH_EN adds periodic self-started frames every REFRESH_CYCLES.
module ws2812b_frame_scheduler
    import ws2812b_pkg::*;
#(
    parameter int N_LEDS         = 8,
    parameter int LATCH_CYCLES   = (CLK_HZ / 1_000_000) * LATCH_US,
    parameter int REFRESH_CYCLES = 450000,
    localparam int IDX_W         = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_frame_done,
    output logic             o_pix_req,
    output logic [IDX_W-1:0] o_pix_idx,
    input  logic             i_pix_valid,
    input  logic [7:0]       i_red,
    input  logic [7:0]       i_green,
    input  logic [7:0]       i_blue,
    output logic             o_send,
    output logic [7:0]       o_red,
    output logic [7:0]       o_green,
    output logic [7:0]       o_blue,
    input  logic             i_done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_LEDS - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    rgb_t             rgb_q, rgb_d;
    logic             frame_q, frame_d;
    logic             latch_tc;
    logic             start_req;

    ws2812b_cycle_timer #(
        .CYCLES (LATCH_CYCLES)
    ) u_latch_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (state_q != ST_LATCH),
        .i_en    (state_q == ST_LATCH),
        .o_tc    (latch_tc)
    );

`ifdef WS2812B_AUTO_REFRESH_EN
    logic refresh_tc;
    logic pending_q, pending_d;

    ws2812b_cycle_timer #(
        .CYCLES (REFRESH_CYCLES)
    ) u_refresh_timer (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (1'b0),
        .i_en    (1'b1),
        .o_tc    (refresh_tc)
    );

    assign start_req = i_start || pending_q;

    // Any start taken in IDLE consumes the pending flag; a wrap in the same cycle re-arms it.
    always_comb begin
        pending_d = pending_q;
        if (state_q == ST_IDLE) begin
            pending_d = 1'b0;
        end
        if (refresh_tc) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pending_q <= 1'b0;
        end else begin
            pending_q <= pending_d;
        end
    end
`else
    // REFRESH_CYCLES has no effect in this build; frames start only on i_start.
    assign start_req = i_start | (1'b0 & (REFRESH_CYCLES > 0));
`endif

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rgb_d   = rgb_q;
        frame_d = frame_q;
        case (state_q)
            ST_LATCH: begin
                // frame_q separates a frame latch (reports done) from the post-reset latch.
                if (latch_tc) begin
                    state_d = frame_q ? ST_DONE : ST_IDLE;
                    frame_d = 1'b0;
                end
            end
            ST_IDLE: begin
                if (start_req) begin
                    state_d = ST_FETCH;
                    idx_d   = '0;
                end
            end
            ST_FETCH: begin
                if (i_pix_valid) begin
                    rgb_d   = '{red: i_red, green: i_green, blue: i_blue};
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (i_done) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_LATCH;
                        frame_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_LATCH;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_LATCH;
            idx_q   <= '0;
            rgb_q   <= '0;
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rgb_q   <= rgb_d;
            frame_q <= frame_d;
        end
    end

    assign o_busy       = (state_q != ST_IDLE);
    assign o_frame_done = (state_q == ST_DONE);
    assign o_pix_req    = (state_q == ST_FETCH);
    assign o_send       = (state_q == ST_SEND);
    assign o_pix_idx    = idx_q;
    assign o_red        = rgb_q.red;
    assign o_green      = rgb_q.green;
    assign o_blue       = rgb_q.blue;

endmodule
